// File: rtl/uart_tx_frame.sv
// UART transmitter: one parallel word per request, framed as start, LSB-first data,
// optional parity and one or two stop bits, with busy/done status.
module uart_tx_frame #(
  parameter int CLKS_PER_BIT = 10416,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 transmit,
  input  logic [DATA_BITS-1:0] data,
  output logic                 TxD,
  output logic                 busy,
  output logic                 done
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IDX_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic                 stop_q, stop_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 par_q, par_d;
  logic                 txd_q, txd_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  // The parity bit is fixed at accept time so shifting the word out cannot disturb it.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    stop_d  = stop_q;
    shreg_d = shreg_q;
    par_d   = par_q;
    txd_d   = txd_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    if (state_q == S_IDLE) begin
      txd_d = 1'b1;
      if (transmit) begin
        shreg_d = data;
        par_d   = (PARITY == 2) ? (^data) : (~^data);
        cnt_d   = '0;
        idx_d   = '0;
        stop_d  = 1'b0;
        busy_d  = 1'b1;
        txd_d   = 1'b0;
        state_d = S_START;
      end
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = '0;
      case (state_q)
        S_START: begin
          txd_d   = shreg_q[0];
          state_d = S_DATA;
        end
        S_DATA: begin
          if (idx_q == IDX_MAX) begin
            if (PARITY != 0) begin
              txd_d   = par_q;
              state_d = S_PARITY;
            end else begin
              txd_d   = 1'b1;
              state_d = S_STOP;
            end
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            shreg_d = shreg_q >> 1;
            txd_d   = shreg_q[1];
          end
        end
        S_PARITY: begin
          txd_d   = 1'b1;
          state_d = S_STOP;
        end
        S_STOP: begin
          txd_d = 1'b1;
          if ((STOP_BITS == 1) || stop_q) begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            stop_d = 1'b1;
          end
        end
        default: begin
          txd_d   = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      stop_q  <= 1'b0;
      shreg_q <= '0;
      par_q   <= 1'b0;
      txd_q   <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      stop_q  <= stop_d;
      shreg_q <= shreg_d;
      par_q   <= par_d;
      txd_q   <= txd_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign TxD  = txd_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Directed bench for uart_tx_frame: four parameterisations share one clock and reset;
// frames are checked cycle by cycle against hand-written bit patterns.
module tb_uart_tx_frame;

  localparam int C = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       transmit [4];
  logic [8:0] data_v   [4];
  logic       txd      [4];
  logic       busy     [4];
  logic       done     [4];

  int checks = 0;
  int errors = 0;
  int done_cnt0 = 0;

  always #5 clk = ~clk;

  // 0: 8N1, 1: 8E1, 2: 8O1, 3: 7N2
  uart_tx_frame #(.CLKS_PER_BIT(C), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_8n1 (
    .clk(clk), .reset(reset), .transmit(transmit[0]), .data(data_v[0][7:0]),
    .TxD(txd[0]), .busy(busy[0]), .done(done[0]));
  uart_tx_frame #(.CLKS_PER_BIT(C), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_8e1 (
    .clk(clk), .reset(reset), .transmit(transmit[1]), .data(data_v[1][7:0]),
    .TxD(txd[1]), .busy(busy[1]), .done(done[1]));
  uart_tx_frame #(.CLKS_PER_BIT(C), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u_8o1 (
    .clk(clk), .reset(reset), .transmit(transmit[2]), .data(data_v[2][7:0]),
    .TxD(txd[2]), .busy(busy[2]), .done(done[2]));
  uart_tx_frame #(.CLKS_PER_BIT(C), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2)) u_7n2 (
    .clk(clk), .reset(reset), .transmit(transmit[3]), .data(data_v[3][6:0]),
    .TxD(txd[3]), .busy(busy[3]), .done(done[3]));

  always @(negedge clk) if (done[0] === 1'b1) done_cnt0++;

  task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called just after a negedge. bits[k] is frame bit k (start = bit 0).
  task automatic run_frame(input int d, input string tag, input logic [15:0] bits,
                           input int nbits, input bit start_req, input bit hold,
                           input int chg_cyc, input logic [8:0] chg_data,
                           input int pulse_cyc, input bit check_after);
    int len;
    len = nbits * C;
    if (start_req) transmit[d] = 1'b1;
    @(posedge clk);
    for (int c = 0; c < len; c++) begin
      @(negedge clk);
      chk($sformatf("%s_txd_c%0d", tag, c), {8'd0, txd[d]}, {8'd0, bits[c / C]});
      chk($sformatf("%s_busy_c%0d", tag, c), {8'd0, busy[d]}, 9'd1);
      chk($sformatf("%s_done_c%0d", tag, c), {8'd0, done[d]}, 9'd0);
      if (c == 0 && !hold) transmit[d] = 1'b0;
      if (c == chg_cyc) data_v[d] = chg_data;
      if (c == pulse_cyc) transmit[d] = 1'b1;
      if (c == pulse_cyc + 1) transmit[d] = 1'b0;
    end
    @(negedge clk);
    chk({tag, "_done_end"}, {8'd0, done[d]}, 9'd1);
    chk({tag, "_busy_end"}, {8'd0, busy[d]}, 9'd0);
    chk({tag, "_txd_end"}, {8'd0, txd[d]}, 9'd1);
    if (check_after) begin
      @(negedge clk);
      chk({tag, "_done_after"}, {8'd0, done[d]}, 9'd0);
      chk({tag, "_busy_after"}, {8'd0, busy[d]}, 9'd0);
      chk({tag, "_txd_after"}, {8'd0, txd[d]}, 9'd1);
    end
  endtask

  initial begin
    int cnt_before;
    for (int i = 0; i < 4; i++) begin
      transmit[i] = 1'b0;
      data_v[i]   = 9'd0;
    end
    reset = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rst_txd%0d", i), {8'd0, txd[i]}, 9'd1);
      chk($sformatf("rst_busy%0d", i), {8'd0, busy[i]}, 9'd0);
      chk($sformatf("rst_done%0d", i), {8'd0, done[i]}, 9'd0);
    end
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // 8N1, 0xA5
    data_v[0] = 9'h0A5;
    run_frame(0, "a5_8n1", 16'b1_10100101_0, 10, 1'b1, 1'b0, 9999, 9'd0, 9999, 1'b1);

    // 8E1 and 8O1, 0x07: even parity 1, odd parity 0
    data_v[1] = 9'h007;
    run_frame(1, "07_8e1", 16'b1_1_00000111_0, 11, 1'b1, 1'b0, 9999, 9'd0, 9999, 1'b1);
    data_v[2] = 9'h007;
    run_frame(2, "07_8o1", 16'b1_0_00000111_0, 11, 1'b1, 1'b0, 9999, 9'd0, 9999, 1'b1);

    // 7N2, 0x41
    data_v[3] = 9'h041;
    run_frame(3, "41_7n2", 16'b11_1000001_0, 10, 1'b1, 1'b0, 9999, 9'd0, 9999, 1'b1);

    // Held request, data changes mid-frame: 0x55 then 0x33 after one idle cycle
    data_v[0] = 9'h055;
    run_frame(0, "b2b_55", 16'b1_01010101_0, 10, 1'b1, 1'b1, 20, 9'h033, 9999, 1'b0);
    run_frame(0, "b2b_33", 16'b1_00110011_0, 10, 1'b0, 1'b0, 9999, 9'd0, 9999, 1'b1);

    // Reset during data bit 3 (frame bit 4, cycles 16..19)
    data_v[0] = 9'h0A5;
    transmit[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    transmit[0] = 1'b0;
    repeat (17) @(negedge clk);
    chk("mid_busy", {8'd0, busy[0]}, 9'd1);
    chk("mid_txd_bit3", {8'd0, txd[0]}, 9'd0);
    reset = 1'b1;
    #1;
    chk("async_rst_txd", {8'd0, txd[0]}, 9'd1);
    chk("async_rst_busy", {8'd0, busy[0]}, 9'd0);
    chk("async_rst_done", {8'd0, done[0]}, 9'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_txd", {8'd0, txd[0]}, 9'd1);
    chk("post_rst_busy", {8'd0, busy[0]}, 9'd0);
    data_v[0] = 9'h03C;
    run_frame(0, "post_rst_3c", 16'b1_00111100_0, 10, 1'b1, 1'b0, 9999, 9'd0, 9999, 1'b1);

    // Request pulsed while busy must be ignored
    cnt_before = done_cnt0;
    data_v[0] = 9'h0C3;
    run_frame(0, "ign_c3", 16'b1_11000011_0, 10, 1'b1, 1'b0, 9999, 9'd0, 10, 1'b1);
    for (int i = 0; i < 3 * C; i++) begin
      @(negedge clk);
      chk($sformatf("ign_idle_txd%0d", i), {8'd0, txd[0]}, 9'd1);
      chk($sformatf("ign_idle_busy%0d", i), {8'd0, busy[0]}, 9'd0);
    end
    #1;
    chk("ign_done_count", 9'(done_cnt0 - cnt_before), 9'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_frame.md
# uart_tx_frame

Parametrised UART transmitter that serialises one parallel word per request onto `TxD`. Data width, parity mode, stop-bit count and baud divisor are configurable. It sits behind the button debouncer and takes the debounced `transmit` level as its start request and the switch bank as `data`. It supersedes the fixed 8N1 transmitter and adds `busy` and `done` status outputs.

## Interface

**Parameters**
- `CLKS_PER_BIT`, default 10416: clock cycles per bit period (100 MHz / 9600 baud); legal range ≥ 2.
- `DATA_BITS`, default 8: payload width; legal range 5–9.
- `PARITY`, default 0: 0 = none, 1 = odd, 2 = even.
- `STOP_BITS`, default 1: legal values 1 or 2.

**Ports**
- `clk`, input, 1: single system clock; all logic is rising-edge.
- `reset`, input, 1: asynchronous, active-high reset.
- `transmit`, input, 1: start request, level-sensitive; sampled only while `busy` = 0.
- `data`, input, `DATA_BITS`: payload; captured on the accept edge.
- `TxD`, output, 1: serial line; idles high; driven from a register.
- `busy`, output, 1: high from the accept edge until the end of the last stop bit.
- `done`, output, 1: one-cycle pulse marking frame completion.

## Operation

**States:** IDLE → START → DATA → PARITY (skipped when `PARITY` = 0) → STOP → IDLE.

**Accept**
- In IDLE, a rising edge with `transmit` = 1 latches `data` into a shift register.
- The same edge clears the baud counter and bit index, sets `busy`, and enters START.

**Baud counter**
- Counts 0..`CLKS_PER_BIT`-1.
- Each state holds `TxD` for exactly `CLKS_PER_BIT` cycles, then advances on terminal count.

**Line values per state**
- START: `TxD` = 0.
- DATA: sends `DATA_BITS` bits, LSB first. The bit index counts 0..`DATA_BITS`-1, and DATA is left after the last index.
- PARITY: even sends `^data`; odd sends `~^data`, so the total count of ones including the parity bit is odd. Parity is computed from the latched word.
- STOP: `TxD` = 1 for `STOP_BITS` × `CLKS_PER_BIT` cycles.

**Completion**
- On the terminal edge of the last stop bit: state → IDLE, `busy` → 0, `done` → 1 for exactly one cycle, `TxD` stays 1.

**Request handling**
- `transmit` is ignored while `busy` = 1. No queueing.
- If `transmit` is held high, frames repeat back-to-back with one idle-high cycle between them.
- Changes on `data` after the accept edge do not affect the frame in flight.

**Reset**
- Asserting `reset`, including mid-frame, immediately forces: `TxD` = 1, `busy` = 0, `done` = 0, state IDLE, all counters and the shift register 0.
- A partial frame is abandoned; no stop bit is appended.

## Timing

- Accept edge at cycle N: `busy` = 1 and `TxD` = 0 are visible from cycle N.
- Frame length L = (1 + `DATA_BITS` + (`PARITY` ≠ 0) + `STOP_BITS`) × `CLKS_PER_BIT` cycles.
- `busy` is high for exactly L cycles. `done` is high in cycle N+L only.
- Earliest next accept edge: N+L, giving a next start bit at N+L+1.
- Bit k of the frame (start = bit 0) occupies cycles N+k·`CLKS_PER_BIT` .. N+(k+1)·`CLKS_PER_BIT`-1.

## Test plan

1. Default 8N1 with `CLKS_PER_BIT` = 4, `data` = 0xA5, one-cycle `transmit` pulse.
   - `TxD` shows 0,1,0,1,0,0,1,0,1 then 1, each bit 4 cycles.
   - `busy` is high for 40 cycles; `done` pulses once at cycle 40.
2. `PARITY` = 2, `data` = 0x07: parity bit = 1. `PARITY` = 1, `data` = 0x07: parity bit = 0.
   - In both cases, frame length is 11 × `CLKS_PER_BIT`.
3. `DATA_BITS` = 7, `STOP_BITS` = 2, `data` = 0x41.
   - Seven data bits 1,0,0,0,0,0,1, then `TxD` high for 8 cycles (with `CLKS_PER_BIT` = 4).
   - `busy` is high for 40 cycles.
4. `transmit` held high, `data` changed from 0x55 to 0x33 mid-frame.
   - The first frame carries 0x55.
   - The second start bit begins exactly 2 cycles after the last stop bit's final cycle (1 idle cycle), carrying 0x33.
5. `reset` asserted during data bit 3.
   - `TxD` = 1, `busy` = 0 and `done` = 0 within the same cycle, no clock edge required.
   - After release, a new request produces a full, correct frame.
6. `transmit` pulsed while `busy` = 1: ignored. Exactly one frame is sent and exactly one `done` pulse is seen.
